// File: rtl/mips_pkg.sv
// Shared definitions for the PC-next slice.
// Contents: FSM state encoding, sequential PC step and jump-address formation.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    WAIT_MEM = 2'd2,
    REDIRECT = 2'd3
  } pcState_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Region bits come from the EX instruction's PC+4; the index fills the word address.
  function automatic logic [31:0] jumpAddr(input logic [31:0] pcExPlus4,
                                           input logic [25:0] jumpIndex);
    return (pcExPlus4 & 32'hF000_0000) | {4'b0000, jumpIndex, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Bus between the PC-next unit and its surroundings.
// Carries EX-stage redirect inputs, the imem handshake and the fetch-side outputs.
interface pc_next_unit_if;
  logic        stall;
  logic        branch_eq;
  logic        branch_ne;
  logic        alu_zero;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc_ex_plus4;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        flush;
  logic        addr_err;

  modport master (
    input  stall, branch_eq, branch_ne, alu_zero, branch_target,
           jump, jump_index, pc_ex_plus4, imem_ready,
    output pc, pc_plus4, pc_valid, flush, addr_err
  );

  modport slave (
    output stall, branch_eq, branch_ne, alu_zero, branch_target,
           jump, jump_index, pc_ex_plus4, imem_ready,
    input  pc, pc_plus4, pc_valid, flush, addr_err
  );
endinterface

// File: rtl/pc_flush_counter.sv
// Flush pulse generator.
// A reload raises flush for FLUSH_CYCLES cycles; reloading mid-count restarts the window.
module pc_flush_counter #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic flush,
  output logic expiring
);

  logic [2:0] cnt_r;
  logic       flush_r;

  // Reload on redirect, otherwise count down; flush drops together with the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 3'd0;
      flush_r <= 1'b0;
    end else if (load) begin
      cnt_r   <= 3'(FLUSH_CYCLES);
      flush_r <= 1'b1;
    end else if (cnt_r != 3'd0) begin
      cnt_r   <= cnt_r - 3'd1;
      flush_r <= (cnt_r > 3'd1);
    end else begin
      cnt_r   <= cnt_r;
      flush_r <= 1'b0;
    end
  end

  assign flush    = flush_r;
  assign expiring = (cnt_r == 3'd1);

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the fetch PC, selects the next PC and drives flush after redirects.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  pc_next_unit_if.master bus
);

  pcState_e    state_r;
  pcState_e    stateNext_s;
  logic [31:0] pc_r;
  logic [31:0] pcNext_s;
  logic [31:0] target_s;
  logic        pcValid_r;
  logic        addrErr_r;
  logic        addrErrNext_s;
  logic        taken_s;
  logic        redirect_s;
  logic        flush_s;
  logic        flushExpiring_s;

  // beq and bne both asserted is treated as taken if either term holds.
  assign taken_s    = (bus.branch_eq & bus.alu_zero) | (bus.branch_ne & ~bus.alu_zero);
  assign redirect_s = bus.jump | taken_s;
  assign target_s   = bus.jump ? jumpAddr(bus.pc_ex_plus4, bus.jump_index) : bus.branch_target;

  // Next-PC priority: jump > taken branch > stall > imem wait > sequential.
  always_comb begin
    stateNext_s   = state_r;
    pcNext_s      = pc_r;
    addrErrNext_s = 1'b0;
    if (redirect_s) begin
      pcNext_s      = {target_s[31:2], 2'b00};
      addrErrNext_s = (target_s[1:0] != 2'b00);
      stateNext_s   = REDIRECT;
    end else begin
      case (state_r)
        BOOT: begin
          stateNext_s = FETCH;
        end
        FETCH: begin
          if (bus.stall) begin
            stateNext_s = FETCH;
          end else if (!bus.imem_ready) begin
            stateNext_s = WAIT_MEM;
          end else begin
            pcNext_s    = pc_r + PC_STEP;
            stateNext_s = FETCH;
          end
        end
        WAIT_MEM: begin
          if (bus.stall) begin
            stateNext_s = WAIT_MEM;
          end else if (bus.imem_ready) begin
            pcNext_s    = pc_r + PC_STEP;
            stateNext_s = FETCH;
          end else begin
            stateNext_s = WAIT_MEM;
          end
        end
        REDIRECT: begin
          if (!bus.stall && bus.imem_ready) begin
            pcNext_s = pc_r + PC_STEP;
          end else begin
            pcNext_s = pc_r;
          end
          if (flushExpiring_s) begin
            stateNext_s = FETCH;
          end else begin
            stateNext_s = REDIRECT;
          end
        end
        default: begin
          stateNext_s = BOOT;
        end
      endcase
    end
  end

  // PC register, FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= BOOT;
      pc_r      <= RESET_VECTOR;
      pcValid_r <= 1'b0;
      addrErr_r <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      pc_r      <= pcNext_s;
      pcValid_r <= 1'b1;
      addrErr_r <= addrErrNext_s;
    end
  end

  pc_flush_counter #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_s),
    .flush   (flush_s),
    .expiring(flushExpiring_s)
  );

  assign bus.pc       = pc_r;
  assign bus.pc_plus4 = pc_r + PC_STEP;
  assign bus.pc_valid = pcValid_r;
  assign bus.flush    = flush_s;
  assign bus.addr_err = addrErr_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit.
// Each step pushes the expected post-edge outputs, clocks once and compares.
module tb_pc_next_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbQ[$];

  pc_next_unit_if bus();

  pc_next_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    check({tag, ".pc"}, bus.pc, e.pc);
    check({tag, ".pc_plus4"}, bus.pc_plus4, e.pc + 32'd4);
    check({tag, ".pc_valid"}, {31'd0, bus.pc_valid}, {31'd0, e.valid});
    check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, e.flush});
    check({tag, ".addr_err"}, {31'd0, bus.addr_err}, {31'd0, e.err});
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.branch_eq     = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.alu_zero      = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'd0;
    bus.pc_ex_plus4   = 32'd0;
    bus.imem_ready    = 1'b1;
  endtask

  task automatic beq(input logic [31:0] target);
    bus.branch_eq     = 1'b1;
    bus.alu_zero      = 1'b1;
    bus.branch_target = target;
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input logic v,
                      input logic f, input logic e);
    exp_t got;
    sbQ.push_back('{pc: pc, valid: v, flush: f, err: e});
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkAll(tag, got);
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset", '{pc: 32'h0, valid: 1'b0, flush: 1'b0, err: 1'b0});
    rst_n = 1'b1;
    #2;
    checkAll("boot_cycle", '{pc: 32'h0, valid: 1'b0, flush: 1'b0, err: 1'b0});

    step("s01_boot", 32'h0, 1'b1, 1'b0, 1'b0);
    step("s02_seq", 32'h4, 1'b1, 1'b0, 1'b0);
    step("s03_seq", 32'h8, 1'b1, 1'b0, 1'b0);
    beq(32'h40);
    step("s04_beq", 32'h40, 1'b1, 1'b1, 1'b0);
    step("s05_flush", 32'h44, 1'b1, 1'b1, 1'b0);
    step("s06_flush_end", 32'h48, 1'b1, 1'b0, 1'b0);
    bus.branch_eq = 1'b1; bus.alu_zero = 1'b0; bus.branch_target = 32'h300;
    step("s07_beq_not_taken", 32'h4C, 1'b1, 1'b0, 1'b0);

    bus.jump = 1'b1; bus.jump_index = 26'h10; bus.pc_ex_plus4 = 32'h1000_0010;
    bus.branch_ne = 1'b1; bus.alu_zero = 1'b0; bus.branch_target = 32'h800;
    step("s08_jump_over_bne", 32'h1000_0040, 1'b1, 1'b1, 1'b0);
    step("s09_flush", 32'h1000_0044, 1'b1, 1'b1, 1'b0);
    bus.branch_ne = 1'b1; bus.alu_zero = 1'b1; bus.branch_target = 32'h300;
    step("s10_bne_not_taken", 32'h1000_0048, 1'b1, 1'b0, 1'b0);

    beq(32'h20);
    step("s11_to_20", 32'h20, 1'b1, 1'b1, 1'b0);
    bus.stall = 1'b1;
    step("s12_stall", 32'h20, 1'b1, 1'b1, 1'b0);
    bus.stall = 1'b1;
    step("s13_stall", 32'h20, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b1;
    step("s14_stall", 32'h20, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b1; beq(32'h80);
    step("s15_branch_in_stall", 32'h80, 1'b1, 1'b1, 1'b0);
    beq(32'h100);
    step("s16_redirect_again", 32'h100, 1'b1, 1'b1, 1'b0);
    step("s17_flush_extended", 32'h104, 1'b1, 1'b1, 1'b0);
    step("s18_flush_end", 32'h108, 1'b1, 1'b0, 1'b0);

    beq(32'h08);
    step("s19_to_08", 32'h8, 1'b1, 1'b1, 1'b0);
    step("s20_seq", 32'hC, 1'b1, 1'b1, 1'b0);
    step("s21_seq", 32'h10, 1'b1, 1'b0, 1'b0);
    bus.imem_ready = 1'b0;
    step("s22_imem_wait", 32'h10, 1'b1, 1'b0, 1'b0);
    bus.imem_ready = 1'b0;
    step("s23_imem_wait", 32'h10, 1'b1, 1'b0, 1'b0);
    step("s24_imem_resume", 32'h14, 1'b1, 1'b0, 1'b0);
    step("s25_seq", 32'h18, 1'b1, 1'b0, 1'b0);
    bus.imem_ready = 1'b0;
    step("s26_imem_wait", 32'h18, 1'b1, 1'b0, 1'b0);
    bus.imem_ready = 1'b0; bus.jump = 1'b1; bus.jump_index = 26'h100;
    step("s27_jump_in_wait", 32'h400, 1'b1, 1'b1, 1'b0);
    step("s28_seq", 32'h404, 1'b1, 1'b1, 1'b0);
    step("s29_seq", 32'h408, 1'b1, 1'b0, 1'b0);

    beq(32'hFFFF_FFF8);
    step("s30_to_top", 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    step("s31_last_word", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    step("s32_wrap", 32'h0, 1'b1, 1'b0, 1'b0);
    beq(32'h42);
    step("s33_misaligned", 32'h40, 1'b1, 1'b1, 1'b1);
    step("s34_err_clear", 32'h44, 1'b1, 1'b1, 1'b0);
    bus.branch_eq = 1'b1; bus.branch_ne = 1'b1; bus.alu_zero = 1'b0;
    bus.branch_target = 32'h200;
    step("s35_eq_and_ne", 32'h200, 1'b1, 1'b1, 1'b0);
    step("s36_mid_flush", 32'h204, 1'b1, 1'b1, 1'b0);

    rst_n = 1'b0;
    #1;
    checkAll("async_reset", '{pc: 32'h0, valid: 1'b0, flush: 1'b0, err: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.stall = 1'b1;
    step("s37_boot_ignores_stall", 32'h0, 1'b1, 1'b0, 1'b0);
    step("s38_seq", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
